// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline constants, control payload and write-back bypass helper for the ID/EX stage.
package id_ex_stage_pkg;

  localparam int unsigned DATA_W        = 16;
  localparam int unsigned REG_W         = 3;
  localparam int unsigned ALUOP_W       = 4;
  localparam int unsigned CNT_W_DEFAULT = 16;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7
  } alu_op_e;

  typedef struct packed {
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
  } ex_ctrl_t;

  // Same-cycle write-back wins over the stale register-file read; r0 never bypasses.
  function automatic logic [DATA_W-1:0] wb_bypass(
    input logic              wb_we,
    input logic [REG_W-1:0]  wb_rd,
    input logic [DATA_W-1:0] wb_data,
    input logic [REG_W-1:0]  src,
    input logic [DATA_W-1:0] file_data
  );
    if (wb_we && (wb_rd != REG_ZERO) && (wb_rd == src)) return wb_data;
    return file_data;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side operands/control, write-back bypass and EX-side pipeline outputs of the ID/EX stage.
interface id_ex_stage_if;
  import id_ex_stage_pkg::*;

  logic               if_id_valid;
  logic [REG_W-1:0]   id_rs;
  logic [REG_W-1:0]   id_rt;
  logic [REG_W-1:0]   id_rd;
  logic               id_uses_rs;
  logic               id_uses_rt;
  logic [DATA_W-1:0]  id_rs_data;
  logic [DATA_W-1:0]  id_rt_data;
  logic [DATA_W-1:0]  id_imm;
  logic               id_reg_write;
  logic               id_mem_read;
  logic               id_mem_write;
  logic               id_mem_to_reg;
  logic               id_alu_src;
  logic [ALUOP_W-1:0] id_alu_op;
  logic               wb_reg_write;
  logic [REG_W-1:0]   wb_rd;
  logic [DATA_W-1:0]  wb_data;
  logic               flush;

  logic               stall;
  logic               pc_write_en;
  logic               if_id_write_en;
  logic               id_ex_valid;
  logic [REG_W-1:0]   id_ex_rs;
  logic [REG_W-1:0]   id_ex_rt;
  logic [REG_W-1:0]   id_ex_rd;
  logic [DATA_W-1:0]  id_ex_rs_data;
  logic [DATA_W-1:0]  id_ex_rt_data;
  logic [DATA_W-1:0]  id_ex_imm;
  logic               id_ex_reg_write;
  logic               id_ex_mem_read;
  logic               id_ex_mem_write;
  logic               id_ex_mem_to_reg;
  logic               id_ex_alu_src;
  logic [ALUOP_W-1:0] id_ex_alu_op;

  modport master (
    output if_id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
           id_rs_data, id_rt_data, id_imm, id_reg_write, id_mem_read,
           id_mem_write, id_mem_to_reg, id_alu_src, id_alu_op,
           wb_reg_write, wb_rd, wb_data, flush,
    input  stall, pc_write_en, if_id_write_en, id_ex_valid,
           id_ex_rs, id_ex_rt, id_ex_rd, id_ex_rs_data, id_ex_rt_data, id_ex_imm,
           id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg,
           id_ex_alu_src, id_ex_alu_op
  );

  modport slave (
    input  if_id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
           id_rs_data, id_rt_data, id_imm, id_reg_write, id_mem_read,
           id_mem_write, id_mem_to_reg, id_alu_src, id_alu_op,
           wb_reg_write, wb_rd, wb_data, flush,
    output stall, pc_write_en, if_id_write_en, id_ex_valid,
           id_ex_rs, id_ex_rt, id_ex_rd, id_ex_rs_data, id_ex_rt_data, id_ex_imm,
           id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg,
           id_ex_alu_src, id_ex_alu_op
  );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard detect: a load in EX whose destination is read by the ID instruction.
module load_use_detect
  import id_ex_stage_pkg::*;
(
  input  logic             if_id_valid_i,
  input  logic             id_uses_rs_i,
  input  logic             id_uses_rt_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             ex_valid_i,
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_rd_i,
  output logic             stall_c_o
);

  logic rs_hit_c;
  logic rt_hit_c;

  assign rs_hit_c  = id_uses_rs_i && (id_rs_i == ex_rd_i);
  assign rt_hit_c  = id_uses_rt_i && (id_rt_i == ex_rd_i);
  assign stall_c_o = if_id_valid_i && ex_valid_i && ex_mem_read_i &&
                     (ex_rd_i != REG_ZERO) && (rs_hit_c || rt_hit_c);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, bubble insertion, write-back bypass and stall counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  id_ex_stage_if.slave     bus,
  output logic [CNT_W-1:0] stall_count
);

  logic              stall_c;

  logic              valid_q,   valid_d;
  logic [REG_W-1:0]  rs_q,      rs_d;
  logic [REG_W-1:0]  rt_q,      rt_d;
  logic [REG_W-1:0]  rd_q,      rd_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q,     imm_d;
  ex_ctrl_t          ctrl_q,    ctrl_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;

  load_use_detect u_load_use_detect (
    .if_id_valid_i (bus.if_id_valid),
    .id_uses_rs_i  (bus.id_uses_rs),
    .id_uses_rt_i  (bus.id_uses_rt),
    .id_rs_i       (bus.id_rs),
    .id_rt_i       (bus.id_rt),
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_rd_i       (rd_q),
    .stall_c_o     (stall_c)
  );

  // Bubble by default; load the ID instruction only when neither flushed nor stalled.
  always_comb begin
    valid_d   = 1'b0;
    rs_d      = REG_ZERO;
    rt_d      = REG_ZERO;
    rd_d      = REG_ZERO;
    rs_data_d = '0;
    rt_data_d = '0;
    imm_d     = '0;
    ctrl_d    = '0;
    cnt_d     = cnt_q;

    if (!bus.flush && !stall_c) begin
      valid_d   = bus.if_id_valid;
      rs_d      = bus.id_rs;
      rt_d      = bus.id_rt;
      rd_d      = bus.id_rd;
      rs_data_d = wb_bypass(bus.wb_reg_write, bus.wb_rd, bus.wb_data, bus.id_rs, bus.id_rs_data);
      rt_data_d = wb_bypass(bus.wb_reg_write, bus.wb_rd, bus.wb_data, bus.id_rt, bus.id_rt_data);
      imm_d     = bus.id_imm;
      if (bus.if_id_valid) begin
        ctrl_d = '{reg_write:  bus.id_reg_write,
                   mem_read:   bus.id_mem_read,
                   mem_write:  bus.id_mem_write,
                   mem_to_reg: bus.id_mem_to_reg,
                   alu_src:    bus.id_alu_src,
                   alu_op:     bus.id_alu_op};
      end
    end

    // A flushed cycle is not a stall cycle as far as the counter is concerned.
    if (stall_c && !bus.flush && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      rs_q      <= REG_ZERO;
      rt_q      <= REG_ZERO;
      rd_q      <= REG_ZERO;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      ctrl_q    <= '0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      ctrl_q    <= ctrl_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.stall            = stall_c;
  assign bus.pc_write_en      = ~stall_c;
  assign bus.if_id_write_en   = ~stall_c;
  assign bus.id_ex_valid      = valid_q;
  assign bus.id_ex_rs         = rs_q;
  assign bus.id_ex_rt         = rt_q;
  assign bus.id_ex_rd         = rd_q;
  assign bus.id_ex_rs_data    = rs_data_q;
  assign bus.id_ex_rt_data    = rt_data_q;
  assign bus.id_ex_imm        = imm_q;
  assign bus.id_ex_reg_write  = ctrl_q.reg_write;
  assign bus.id_ex_mem_read   = ctrl_q.mem_read;
  assign bus.id_ex_mem_write  = ctrl_q.mem_write;
  assign bus.id_ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.id_ex_alu_src    = ctrl_q.alu_src;
  assign bus.id_ex_alu_op     = ctrl_q.alu_op;
  assign stall_count          = cnt_q;

endmodule
